power_spectrum_buffer: RTL

Frame buffer and read-port responder that sits between the FFT stage and the mel filterbank in the MFCC pipeline. It accepts one streamed FFT frame of complex bins, computes and stores the power of the first RNFFT bins, then pulses the mel start and serves the mel block's combinational bin reads until the mel block signals done. It blocks new FFT input while a frame is being consumed, so a frame is never overwritten mid-filterbank.

---
 rtl/power_spectrum_buffer.sv | 64 ++++++
 1 files changed

// File: rtl/power_spectrum_buffer.sv
// power_spectrum_buffer: stores |X|^2 of one FFT frame and serves it to the mel filterbank
module power_spectrum_buffer #(
    parameter int NFFT  = 512,
    parameter int RNFFT = NFFT / 2 + 1,
    parameter int IN_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fft_valid_i,
    output logic                     fft_ready_o,
    input  logic [IN_W-1:0]          fft_re_i,
    input  logic [IN_W-1:0]          fft_im_i,
    input  logic                     fft_last_i,
    output logic                     mel_start_o,
    input  logic                     mel_done_i,
    input  logic [$clog2(RNFFT):0]   prt_power_spectrum_frame_i,
    output logic [31:0]              value_power_spectrum_frame_o,
    output logic                     frame_err_o,
    output logic                     busy_o
);
    localparam int CW = $clog2(NFFT);
    localparam int AW = $clog2(RNFFT);
    typedef enum logic [1:0] {FILL, START, BUSY} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] bin_cnt;
    logic [31:0] mem [RNFFT];
    logic signed [2*IN_W-1:0] sq_re, sq_im;
    logic [31:0] power;
    logic hs, cnt_end, frame_end, good_end;
    assign hs = fft_valid_i && fft_ready_o;
    assign cnt_end = bin_cnt == CW'(NFFT - 1);
    assign frame_end = hs && (cnt_end || fft_last_i);
    assign good_end = hs && cnt_end && fft_last_i;
    assign sq_re = $signed(fft_re_i) * $signed(fft_re_i);
    assign sq_im = $signed(fft_im_i) * $signed(fft_im_i);
    // both squares are non-negative, so the sum of up to 2^31 fits unsigned 32 bits
    assign power = 32'($unsigned(sq_re)) + 32'($unsigned(sq_im));
    assign fft_ready_o = state == FILL;
    assign mel_start_o = state == START;
    assign busy_o = state != FILL;
    assign value_power_spectrum_frame_o = prt_power_spectrum_frame_i < (AW + 1)'(RNFFT)
                                          ? mem[prt_power_spectrum_frame_i[AW-1:0]] : '0;
    always_comb begin
        state_nxt = state == FILL  ? (good_end ? START : FILL)
                  : state == START ? BUSY
                  : mel_done_i     ? FILL : BUSY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILL;
        else        state <= state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= frame_end && !good_end;
            if (hs) bin_cnt <= frame_end ? '0 : bin_cnt + CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (hs && bin_cnt < CW'(RNFFT)) mem[AW'(bin_cnt)] <= power;
    end
endmodule
